traffic_phase_controller: RTL and testbench

Main-street/side-street traffic light sequencer. Selects the active phase duration through the `time_selector`/`value` pair of the time-parameter block and counts it down with the 1 Hz enable. It latches the side-street sensor and pedestrian walk request, and drives the six signal lamps plus the walk lamp. It sits between the synchronizer/divider front end and the LED outputs.

---
 rtl/traffic_pkg.sv | 51 +++++
 rtl/traffic_phase_controller_timer.sv | 45 ++++
 rtl/traffic_phase_controller.sv | 110 +++++++++++
 tb/tb_traffic_phase_controller.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the traffic phase controller
// Phase codes, selector encodings, timer settle states and the lamp bundle.
package traffic_pkg;

  typedef enum logic [2:0] {
    MG_BASE = 3'd0,
    MG_EXT  = 3'd1,
    MY      = 3'd2,
    WALK    = 3'd3,
    SG_BASE = 3'd4,
    SG_EXT  = 3'd5,
    SY      = 3'd6
  } phase_t;

  typedef enum logic [1:0] {
    SETTLE_E1 = 2'd0,
    SETTLE_E2 = 2'd1,
    RUNNING   = 2'd2
  } settle_t;

  localparam logic [1:0] SEL_BASE  = 2'b00;
  localparam logic [1:0] SEL_EXT   = 2'b01;
  localparam logic [1:0] SEL_YEL   = 2'b10;
  localparam logic [1:0] SEL_2BASE = 2'b11;

  typedef struct packed {
    logic main_r;
    logic main_y;
    logic main_g;
    logic side_r;
    logic side_y;
    logic side_g;
    logic walk;
  } lamps_t;

  function automatic lamps_t lamps_of(input phase_t s);
    lamps_t l;
    l = '{main_r: 1'b1, main_y: 1'b0, main_g: 1'b0,
          side_r: 1'b1, side_y: 1'b0, side_g: 1'b0, walk: 1'b0};
    case (s)
      MG_BASE, MG_EXT: begin l.main_r = 1'b0; l.main_g = 1'b1; end
      MY:              begin l.main_r = 1'b0; l.main_y = 1'b1; end
      WALK:            l.walk = 1'b1;
      SG_BASE, SG_EXT: begin l.side_r = 1'b0; l.side_g = 1'b1; end
      SY:              begin l.side_r = 1'b0; l.side_y = 1'b1; end
      default:         l.walk = 1'b0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_timer.sv
// rtl/traffic_phase_controller_timer.sv - phase countdown with two-cycle settle
// Waits for the selector/value pipeline, loads the duration, then counts ticks to expiry.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int TICK_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              tick,
  input  logic [TICK_W-1:0] value,
  output logic              expire
);

  localparam logic [TICK_W-1:0] ONE = TICK_W'(1);

  settle_t           r_settle;
  logic [TICK_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= SETTLE_E1;
      r_count  <= '0;
    end else if (restart) begin
      r_settle <= SETTLE_E1;
    end else begin
      case (r_settle)
        SETTLE_E1: r_settle <= SETTLE_E2;
        SETTLE_E2: begin
          // A zero duration still gives one full tick; the counter never wraps.
          r_settle <= RUNNING;
          r_count  <= (value == '0) ? ONE : value;
        end
        RUNNING: begin
          if (tick && (r_count > ONE)) r_count <= r_count - ONE;
        end
        default: r_settle <= SETTLE_E1;
      endcase
    end
  end

  assign expire = (r_settle == RUNNING) && tick && (r_count == ONE);

endmodule

// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - main/side street light sequencer top
// Phase FSM, sensor/walk latches, registered selector and lamp decode.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int TICK_W = 4
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              one_hz_enable,
  input  logic              sensor_sync,
  input  logic              walk_request_sync,
  input  logic              prog_sync,
  input  logic [TICK_W-1:0] value,
  output logic [1:0]        time_selector,
  output logic              main_r,
  output logic              main_y,
  output logic              main_g,
  output logic              side_r,
  output logic              side_y,
  output logic              side_g,
  output logic              walk_lamp,
  output logic [2:0]        phase_state
);

  phase_t     r_state;
  phase_t     w_next;
  logic       r_sensor_seen;
  logic       r_walk_latched;
  logic [1:0] r_sel;
  logic       w_sensor_eff;
  logic       w_walk_eff;
  logic       w_sensor_nxt;
  logic       w_walk_nxt;
  logic [1:0] w_sel_nxt;
  logic       w_expire;
  logic       w_restart;
  lamps_t     w_lamps;

  assign w_restart = w_expire | prog_sync;

  phase_timer #(.TICK_W(TICK_W)) u_timer (
    .clk     (clk),
    .rst_n   (Reset_n),
    .restart (w_restart),
    .tick    (one_hz_enable),
    .value   (value),
    .expire  (w_expire)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state        <= MG_BASE;
      r_sel          <= SEL_BASE;
      r_sensor_seen  <= 1'b0;
      r_walk_latched <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_sel          <= w_sel_nxt;
      r_sensor_seen  <= w_sensor_nxt;
      r_walk_latched <= w_walk_nxt;
    end
  end

  always_comb begin
    // Inputs in the expiry cycle take part in that cycle's decision.
    w_sensor_eff = r_sensor_seen |
                   (sensor_sync & ((r_state == MG_BASE) || (r_state == SG_BASE)));
    w_walk_eff   = r_walk_latched | (walk_request_sync & (r_state != WALK));

    w_next = r_state;
    if (prog_sync) begin
      w_next = MG_BASE;
    end else if (w_expire) begin
      case (r_state)
        MG_BASE: w_next = MG_EXT;
        MG_EXT:  w_next = MY;
        MY:      w_next = w_walk_eff ? WALK : SG_BASE;
        WALK:    w_next = SG_BASE;
        SG_BASE: w_next = w_sensor_eff ? SG_EXT : SY;
        SG_EXT:  w_next = SY;
        SY:      w_next = MG_BASE;
        default: w_next = MG_BASE;
      endcase
    end

    w_sensor_nxt = w_sensor_eff;
    if (prog_sync || (w_next == MY) || (w_next == SY)) w_sensor_nxt = 1'b0;

    w_walk_nxt = w_walk_eff;
    if (prog_sync || (w_next == WALK)) w_walk_nxt = 1'b0;

    case (w_next)
      MG_BASE: w_sel_nxt = SEL_BASE;
      MG_EXT:  w_sel_nxt = w_sensor_nxt ? SEL_EXT : SEL_BASE;
      MY:      w_sel_nxt = SEL_YEL;
      WALK:    w_sel_nxt = SEL_EXT;
      SG_BASE: w_sel_nxt = SEL_BASE;
      SG_EXT:  w_sel_nxt = SEL_EXT;
      SY:      w_sel_nxt = SEL_YEL;
      default: w_sel_nxt = SEL_BASE;
    endcase
  end

  assign w_lamps       = lamps_of(r_state);
  assign {main_r, main_y, main_g, side_r, side_y, side_g, walk_lamp} = w_lamps;
  assign time_selector = r_sel;
  assign phase_state   = r_state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - scoreboard bench for traffic_phase_controller
// Models the time-parameter block and a tick divider; checks each phase on exit.
module tb_traffic_phase_controller;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       one_hz_enable = 1'b0;
  logic       sensor_sync = 1'b0;
  logic       walk_request_sync = 1'b0;
  logic       prog_sync = 1'b0;
  logic [3:0] value;
  logic [1:0] time_selector;
  logic       main_r, main_y, main_g, side_r, side_y, side_g, walk_lamp;
  logic [2:0] phase_state;

  int checks = 0;
  int errors = 0;
  int t_base = 6, t_ext = 3, t_yel = 2;
  int tick_div = 0;

  typedef struct {
    logic [2:0] st;
    int         ticks;
    logic [1:0] sel;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic       mon_en = 1'b0;
  logic [2:0] prev;
  int         tcnt;
  logic [1:0] ent_sel;
  logic [6:0] ent_lamps;

  always #5 clk = ~clk;

  traffic_phase_controller #(.TICK_W(4)) dut (
    .clk               (clk),
    .Reset_n           (Reset_n),
    .one_hz_enable     (one_hz_enable),
    .sensor_sync       (sensor_sync),
    .walk_request_sync (walk_request_sync),
    .prog_sync         (prog_sync),
    .value             (value),
    .time_selector     (time_selector),
    .main_r            (main_r),
    .main_y            (main_y),
    .main_g            (main_g),
    .side_r            (side_r),
    .side_y            (side_y),
    .side_g            (side_g),
    .walk_lamp         (walk_lamp),
    .phase_state       (phase_state)
  );

  // Time-parameter block: registered lookup of the selector.
  always @(posedge clk) begin
    case (time_selector)
      2'b00:   value <= 4'(t_base);
      2'b01:   value <= 4'(t_ext);
      2'b10:   value <= 4'(t_yel);
      default: value <= 4'(2 * t_base);
    endcase
  end

  // Tick every 10 cycles; updated 2 time units after the edge.
  always @(posedge clk) begin
    #2;
    if (!Reset_n) begin
      tick_div      = 0;
      one_hz_enable = 1'b0;
    end else begin
      tick_div      = (tick_div == 9) ? 0 : tick_div + 1;
      one_hz_enable = (tick_div == 9);
    end
  end

  function automatic logic [6:0] exp_lamps(input logic [2:0] st);
    case (st)
      3'd0, 3'd1: return 7'b0011000;
      3'd2:       return 7'b0101000;
      3'd3:       return 7'b1001001;
      3'd4, 3'd5: return 7'b1000010;
      3'd6:       return 7'b1000100;
      default:    return 7'b1001000;
    endcase
  endfunction

  function automatic logic [6:0] cur_lamps();
    return {main_r, main_y, main_g, side_r, side_y, side_g, walk_lamp};
  endfunction

  // Phase monitor: a tick at the transition edge belongs to the phase being left.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (one_hz_enable) tcnt++;
      if (phase_state !== prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transition %0d->%0d with empty scoreboard", prev, phase_state);
        end else begin
          mon_e = sb.pop_front();
          checks += 4;
          if (prev !== mon_e.st) begin
            errors++;
            $display("FAIL phase_order got %0d expected %0d", prev, mon_e.st);
          end
          if (tcnt !== mon_e.ticks) begin
            errors++;
            $display("FAIL phase_ticks state %0d got %0d expected %0d", mon_e.st, tcnt, mon_e.ticks);
          end
          if (ent_sel !== mon_e.sel) begin
            errors++;
            $display("FAIL phase_sel state %0d got %b expected %b", mon_e.st, ent_sel, mon_e.sel);
          end
          if (ent_lamps !== exp_lamps(mon_e.st)) begin
            errors++;
            $display("FAIL phase_lamps state %0d got %b expected %b", mon_e.st, ent_lamps, exp_lamps(mon_e.st));
          end
        end
        prev      = phase_state;
        tcnt      = 0;
        ent_sel   = time_selector;
        ent_lamps = cur_lamps();
      end
    end
  end

  task automatic push(input logic [2:0] st, input int ticks, input logic [1:0] sel);
    exp_t e;
    e.st = st; e.ticks = ticks; e.sel = sel;
    sb.push_back(e);
  endtask

  task automatic start_mon();
    prev      = MG_BASE;
    tcnt      = 0;
    ent_sel   = time_selector;
    ent_lamps = cur_lamps();
    mon_en    = 1'b1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    sb.delete();
    sensor_sync = 1'b0; walk_request_sync = 1'b0; prog_sync = 1'b0;
    Reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 Reset_n = 1'b1;
    start_mon();
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk); #4;
      if (phase_state == st) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s timeout waiting for state %0d, at %0d", name, st, phase_state);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain timeout, %0d phases outstanding", name, sb.size());
    end
  endtask

  task automatic pulse_sensor();
    #4 sensor_sync = 1'b1;
    @(posedge clk); #4 sensor_sync = 1'b0;
  endtask

  task automatic pulse_walk();
    #4 walk_request_sync = 1'b1;
    @(posedge clk); #4 walk_request_sync = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (phase_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", phase_state); end
    if (time_selector !== 2'b00) begin errors++; $display("FAIL reset_sel got %b expected 00", time_selector); end
    if (cur_lamps() !== 7'b0011000) begin errors++; $display("FAIL reset_lamps got %b expected 0011000", cur_lamps()); end
    if (dut.u_timer.r_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", dut.u_timer.r_count); end
  endtask

  task automatic test_default_cycle();
    t_base = 6; t_ext = 3; t_yel = 2;
    do_reset();
    push(MG_BASE, 6, 2'b00); push(MG_EXT, 6, 2'b00); push(MY, 2, 2'b10);
    push(SG_BASE, 6, 2'b00); push(SY, 2, 2'b10);
    wait_drain(1000, "default_cycle");
  endtask

  task automatic test_sensor();
    do_reset();
    push(MG_BASE, 6, 2'b00); push(MG_EXT, 3, 2'b01); push(MY, 2, 2'b10);
    push(SG_BASE, 6, 2'b00); push(SG_EXT, 3, 2'b01); push(SY, 2, 2'b10);
    repeat (20) @(posedge clk);
    pulse_sensor();
    wait_state(SG_BASE, 500, "sensor_sg_base");
    repeat (20) @(posedge clk);
    pulse_sensor();
    wait_drain(600, "sensor");
  endtask

  task automatic test_walk();
    do_reset();
    push(MG_BASE, 6, 2'b00); push(MG_EXT, 6, 2'b00); push(MY, 2, 2'b10);
    push(SG_BASE, 6, 2'b00); push(SY, 2, 2'b10);
    push(MG_BASE, 6, 2'b00); push(MG_EXT, 6, 2'b00); push(MY, 2, 2'b10);
    push(WALK, 3, 2'b01); push(SG_BASE, 6, 2'b00); push(SY, 2, 2'b10);
    push(MG_BASE, 6, 2'b00); push(MG_EXT, 6, 2'b00); push(MY, 2, 2'b10);
    push(SG_BASE, 6, 2'b00);
    wait_state(SG_BASE, 500, "walk_sg_base");
    repeat (15) @(posedge clk);
    pulse_walk();
    wait_state(WALK, 1000, "walk_enter");
    repeat (12) @(posedge clk);
    pulse_walk();
    wait_drain(1500, "walk");
  endtask

  task automatic test_prog();
    do_reset();
    push(MG_BASE, 6, 2'b00); push(MG_EXT, 6, 2'b00); push(MY, 2, 2'b10);
    push(SG_BASE, 6, 2'b00); push(SY, 0, 2'b10);
    push(MG_BASE, 6, 2'b00); push(MG_EXT, 6, 2'b00); push(MY, 2, 2'b10);
    push(SG_BASE, 6, 2'b00);
    wait_state(SY, 600, "prog_sy");
    repeat (3) @(posedge clk);
    pulse_walk();
    prog_sync = 1'b1;
    @(posedge clk); #4 prog_sync = 1'b0;
    checks += 2;
    if (phase_state !== 3'd0) begin errors++; $display("FAIL prog_state got %0d expected 0", phase_state); end
    if (time_selector !== 2'b00) begin errors++; $display("FAIL prog_sel got %b expected 00", time_selector); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut.u_timer.r_count !== 4'd6) begin errors++; $display("FAIL prog_reload got %0d expected 6", dut.u_timer.r_count); end
    wait_drain(800, "prog");
  endtask

  task automatic test_zero_and_e1_tick();
    bit aligned = 1'b0;
    t_yel = 0;
    do_reset();
    push(MG_BASE, 6, 2'b00); push(MG_EXT, 6, 2'b00); push(MY, 1, 2'b10);
    push(SG_BASE, 6, 2'b00); push(SY, 1, 2'b10);
    push(MG_BASE, 6, 2'b00); push(MG_EXT, 0, 2'b00);
    // The reprogram lands one cycle before a tick, so that tick hits E1 and is ignored.
    push(MG_BASE, 7, 2'b00); push(MG_EXT, 6, 2'b00);
    wait_state(SY, 600, "zero_sy");
    wait_state(MG_EXT, 300, "zero_mg_ext");
    for (int i = 0; i < 20 && !aligned; i++) begin
      @(posedge clk); #3;
      if (tick_div == 8) aligned = 1'b1;
    end
    prog_sync = 1'b1;
    @(posedge clk); #3 prog_sync = 1'b0;
    wait_drain(600, "zero_e1");
    t_yel = 2;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(MG_BASE, 6, 2'b00); push(MG_EXT, 6, 2'b00); push(MY, 2, 2'b10);
    push(SG_BASE, 6, 2'b00);
    wait_state(SG_BASE, 500, "rst_sg_base");
    repeat (20) @(posedge clk);
    pulse_sensor();
    wait_state(SG_EXT, 300, "rst_sg_ext");
    repeat (5) @(posedge clk);
    #3;
    mon_en = 1'b0;
    Reset_n = 1'b0;
    #1;
    checks += 5;
    if (sb.size() != 0) begin errors++; $display("FAIL rst_pending got %0d expected 0", sb.size()); end
    if (main_g !== 1'b1) begin errors++; $display("FAIL rst_main_g got %b expected 1", main_g); end
    if (side_r !== 1'b1) begin errors++; $display("FAIL rst_side_r got %b expected 1", side_r); end
    if (side_g !== 1'b0) begin errors++; $display("FAIL rst_side_g got %b expected 0", side_g); end
    if (time_selector !== 2'b00) begin errors++; $display("FAIL rst_sel got %b expected 00", time_selector); end
    repeat (2) @(posedge clk);
    #3 Reset_n = 1'b1;
    start_mon();
    push(MG_BASE, 6, 2'b00);
    @(posedge clk); #1;
    checks++;
    if (dut.u_timer.r_count !== 4'd0) begin errors++; $display("FAIL rst_e1_count got %0d expected 0", dut.u_timer.r_count); end
    @(posedge clk); #1;
    checks++;
    if (dut.u_timer.r_count !== 4'd6) begin errors++; $display("FAIL rst_e2_count got %0d expected 6", dut.u_timer.r_count); end
    wait_drain(300, "rst_mid");
  endtask

  initial begin
    test_reset();
    test_default_cycle();
    test_sensor();
    test_walk();
    test_prog();
    test_zero_and_e1_tick();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
